// File: rtl/lstm_pkg.sv
// Shared fixed-point constants and activation helpers for the LSTM cell update path.
// The helpers operate on the package word width (DW).
package lstm_pkg;

    localparam int DW   = 16;
    localparam int FRAC = 8;

    typedef logic signed [DW-1:0] fxp_t;

    localparam fxp_t ONE     = fxp_t'(1 << FRAC);
    localparam fxp_t HALF    = fxp_t'(1 << (FRAC - 1));
    localparam fxp_t NEG_ONE = -ONE;
    localparam fxp_t MAX_V   = {1'b0, {(DW-1){1'b1}}};
    localparam fxp_t MIN_V   = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {GATE_I, GATE_F, GATE_G, GATE_O} gate_e;

    function automatic fxp_t sat_add(input fxp_t a, input fxp_t b);
        logic signed [DW:0] s;
        s = (DW+1)'(a) + (DW+1)'(b);
        if (s[DW] != s[DW-1])
            return s[DW] ? MIN_V : MAX_V;
        return s[DW-1:0];
    endfunction

    // Hard sigmoid: x/4 + 0.5, clamped to [0, 1].
    function automatic fxp_t hsig(input fxp_t x);
        logic signed [DW:0] s;
        s = (DW+1)'(x >>> 2) + (DW+1)'(HALF);
        if (s < 0)
            return '0;
        if (s > (DW+1)'(ONE))
            return ONE;
        return s[DW-1:0];
    endfunction

    function automatic fxp_t htanh(input fxp_t x);
        if (x > ONE)
            return ONE;
        if (x < NEG_ONE)
            return NEG_ONE;
        return x;
    endfunction

endpackage

// File: rtl/lstm_fxp_mul.sv
// Signed fixed-point multiply: full product, round half up, shift by FRAC, saturate.
module lstm_fxp_mul #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] p_o
);

    localparam int PW = 2*WIDTH + 1;
    localparam logic signed [PW-1:0] RHALF = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [PW-1:0] MAXV  = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV  = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;

    assign prod = PW'(a_i) * PW'(b_i);
    assign rnd  = (prod + RHALF) >>> FRAC;

    always_comb begin
        p_o = rnd[WIDTH-1:0];
        if (rnd > MAXV)
            p_o = MAXV[WIDTH-1:0];
        else if (rnd < MINV)
            p_o = MINV[WIDTH-1:0];
    end

endmodule

// File: rtl/lstm_cell_update.sv
// LSTM cell update: C = sig(f)*C_prev + sig(i)*tanh(g), h = sig(o)*tanh(C).
// Four-stage pipeline under one global enable driven by output backpressure.
module lstm_cell_update #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [3:0][WIDTH-1:0] gate_pre,
    input  logic signed [WIDTH-1:0]      c_prev,
    input  logic                         pre_valid,
    output logic                         pre_ready,
    output logic signed [WIDTH-1:0]      c_out,
    output logic signed [WIDTH-1:0]      h_out,
    output logic                         out_valid,
    input  logic                         out_ready
);
    import lstm_pkg::*;

    typedef logic signed [WIDTH-1:0] word_t;

    logic  en;
    logic  v1_q, v2_q, v3_q, v4_q;
    word_t si_q, sf_q, tg_q, so_q, cp_q;
    word_t fc_q, ig_q, o2_q;
    word_t c3_q, t3_q, o3_q;
    word_t c_out_q, h_out_q;
    word_t fc_d, ig_d, c3_d, h_d;

    assign en        = !v4_q || out_ready;
    assign pre_ready = en;
    assign out_valid = v4_q;
    assign c_out     = c_out_q;
    assign h_out     = h_out_q;

    lstm_fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_fc (.a_i(sf_q), .b_i(cp_q), .p_o(fc_d));
    lstm_fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ig (.a_i(si_q), .b_i(tg_q), .p_o(ig_d));
    lstm_fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_h  (.a_i(o3_q), .b_i(t3_q), .p_o(h_d));

    assign c3_d = sat_add(fc_q, ig_q);

    // Data registers load on every enabled cycle; bubbles carry junk tagged v=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            v4_q    <= 1'b0;
            si_q    <= '0;
            sf_q    <= '0;
            tg_q    <= '0;
            so_q    <= '0;
            cp_q    <= '0;
            fc_q    <= '0;
            ig_q    <= '0;
            o2_q    <= '0;
            c3_q    <= '0;
            t3_q    <= '0;
            o3_q    <= '0;
            c_out_q <= '0;
            h_out_q <= '0;
        end else if (en) begin
            v1_q    <= pre_valid;
            si_q    <= hsig(gate_pre[GATE_I]);
            sf_q    <= hsig(gate_pre[GATE_F]);
            tg_q    <= htanh(gate_pre[GATE_G]);
            so_q    <= hsig(gate_pre[GATE_O]);
            cp_q    <= c_prev;

            v2_q    <= v1_q;
            fc_q    <= fc_d;
            ig_q    <= ig_d;
            o2_q    <= so_q;

            v3_q    <= v2_q;
            c3_q    <= c3_d;
            t3_q    <= htanh(c3_d);
            o3_q    <= o2_q;

            v4_q    <= v3_q;
            c_out_q <= c3_q;
            h_out_q <= h_d;
        end
    end

endmodule

// File: tb/tb_lstm_cell_update.sv
// Scoreboard bench for lstm_cell_update: directed vectors with hand-computed results.
module tb_lstm_cell_update;

    localparam int W = 16;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic signed [3:0][W-1:0] gate_pre = '0;
    logic signed [W-1:0]      c_prev = '0;
    logic                     pre_valid = 1'b0;
    logic                     pre_ready;
    logic signed [W-1:0]      c_out, h_out;
    logic                     out_valid;
    logic                     out_ready = 1'b1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ov_cnt = 0;
    bit chk_lat = 1'b1;

    logic signed [W-1:0] exp_c_cur, exp_h_cur;
    logic signed [W-1:0] exp_c_q[$];
    logic signed [W-1:0] exp_h_q[$];
    int                  acc_q[$];

    typedef struct {
        int i, f, g, o, c, ec, eh;
    } vec_t;

    // {i, f, g, o, c_prev, expected c_out, expected h_out}
    vec_t vt[10] = '{
        '{0, 0, 0, 0, 256, 128, 64},
        '{2048, 2048, 2048, 2048, 32767, 32767, 256},
        '{-2048, -2048, -2048, -2048, -1000, 0, 0},
        '{0, 0, 256, 0, 0, 128, 64},
        '{512, -512, -100, 512, 5000, -100, -100},
        '{100, 200, 300, -100, 1000, 848, 103},
        '{-3, 0, -7, 0, -3, -4, -2},
        '{2048, 2048, -2048, -1000, -32768, -32768, 0},
        '{20000, -20000, 200, 300, 0, 200, 159},
        '{511, -513, 255, -512, 77, 254, 0}
    };

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lstm_cell_update #(.WIDTH(W), .FRAC(8)) dut (
        .clk(clk), .rst(rst), .gate_pre(gate_pre), .c_prev(c_prev),
        .pre_valid(pre_valid), .pre_ready(pre_ready),
        .c_out(c_out), .h_out(h_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Input side of the scoreboard: one push per accepted sample.
    always @(negedge clk) begin
        if (!rst && pre_valid && pre_ready) begin
            exp_c_q.push_back(exp_c_cur);
            exp_h_q.push_back(exp_h_cur);
            acc_q.push_back(cyc);
        end
    end

    // Output side: pop on each output transfer, check hold behaviour while stalled.
    logic signed [W-1:0] prev_c, prev_h;
    bit prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_c", int'(c_out), int'(prev_c));
                chk("hold_h", int'(h_out), int'(prev_h));
            end
            if (out_valid && !out_ready)
                chk("stall_pre_ready", int'(pre_ready), 0);
            if (out_valid && out_ready) begin
                ov_cnt++;
                if (exp_c_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    int a;
                    chk("c_out", int'(c_out), int'(exp_c_q.pop_front()));
                    chk("h_out", int'(h_out), int'(exp_h_q.pop_front()));
                    a = acc_q.pop_front();
                    if (chk_lat)
                        chk("latency", cyc - a, 4);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_c = c_out;
            prev_h = h_out;
        end
    end

    task automatic send(input int k);
        int n;
        gate_pre[0] = W'(vt[k].i);
        gate_pre[1] = W'(vt[k].f);
        gate_pre[2] = W'(vt[k].g);
        gate_pre[3] = W'(vt[k].o);
        c_prev      = W'(vt[k].c);
        exp_c_cur   = W'(vt[k].ec);
        exp_h_cur   = W'(vt[k].eh);
        pre_valid   = 1'b1;
        @(negedge clk);
        n = 0;
        while (!pre_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!pre_ready)
            chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        pre_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_c_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_left", exp_c_q.size(), 0);
    endtask

    initial begin
        int ov0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_c_out", int'(c_out), 0);
        chk("rst_h_out", int'(h_out), 0);
        chk("rst_pre_ready", int'(pre_ready), 1);
        @(posedge clk);
        #1;

        // Single samples: zero gates, saturation, negative gates.
        ov0 = ov_cnt;
        send(0);
        drain();
        chk("zero_one_valid_cycle", ov_cnt - ov0, 1);
        send(1);
        drain();
        send(2);
        drain();

        // Back-to-back stream of 8.
        for (int k = 3; k < 11; k++)
            send(k % 10);
        drain();

        // Backpressure during a 6-sample stream.
        chk_lat = 1'b0;
        fork
            begin
                for (int k = 4; k < 10; k++)
                    send(k);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk_lat = 1'b1;

        // Reset with three samples in flight.
        send(5);
        send(6);
        send(7);
        rst = 1'b1;
        exp_c_q.delete();
        exp_h_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_c_out", int'(c_out), 0);
        chk("midrst_h_out", int'(h_out), 0);
        repeat (10) @(posedge clk);
        #1;
        send(9);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
